// File: rtl/flow_pkg.sv
// flow_pkg: shared fetch-stage constants and state encoding.
package flow_pkg;
    localparam int PC_WIDTH = 16;
    localparam logic [PC_WIDTH-1:0] HALT_INSTR = 16'h0300;
    localparam logic [PC_WIDTH-1:0] DEFAULT_NOP = 16'h0000;
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t CAPTURE = 2'd1;
    localparam fetch_state_t READY = 2'd2;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and synchronous-ROM fetch stage with bubble insertion.
// Define FETCH_BREAKPOINT_EN to add a one-shot PC breakpoint that substitutes HALT_INSTR.
module instruction_fetch
    import flow_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter logic [PC_WIDTH-1:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  program_counter_increment,
    input  logic                  pc_load,
    input  logic [PC_WIDTH-1:0]   pc_load_value,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [PC_WIDTH-1:0]   imem_rdata,
`ifdef FETCH_BREAKPOINT_EN
    input  logic [PC_WIDTH-1:0]   breakpoint_addr,
    input  logic                  breakpoint_enable,
    output logic                  break_hit,
`endif
    output logic [PC_WIDTH-1:0]   current_instruction,
    output logic                  instruction_valid,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [PC_WIDTH-1:0]   retired_count
);
    fetch_state_t state;
    logic [PC_WIDTH-1:0] capture_data;
    logic take_inc;
    logic do_capture;

    assign imem_addr = pc[ADDR_WIDTH-1:0];
    assign take_inc = state == READY && program_counter_increment && !pc_load;
    // A load in CAPTURE discards the in-flight read.
    assign do_capture = state == CAPTURE && !pc_load;

`ifdef FETCH_BREAKPOINT_EN
    logic armed;
    logic bp_match;

    assign bp_match = breakpoint_enable && armed && pc == breakpoint_addr;
    assign capture_data = bp_match ? HALT_INSTR : imem_rdata;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            armed <= 1'b1;
            break_hit <= 1'b0;
        end else begin
            break_hit <= do_capture && bp_match;
            if (pc != breakpoint_addr) armed <= 1'b1;
            else if (do_capture && bp_match) armed <= 1'b0;
        end
    end
`else
    assign capture_data = imem_rdata;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= FETCH;
            pc <= RESET_VECTOR;
            retired_count <= '0;
            instruction_valid <= 1'b0;
            current_instruction <= NOP_INSTR;
        end else begin
            if (pc_load) begin
                pc <= pc_load_value;
                state <= FETCH;
            end else if (take_inc) begin
                pc <= pc + 1'b1;
                retired_count <= retired_count + 1'b1;
                state <= FETCH;
            end else if (state == FETCH) begin
                state <= CAPTURE;
            end else if (state == CAPTURE) begin
                state <= READY;
            end
            if (do_capture) begin
                current_instruction <= capture_data;
                instruction_valid <= 1'b1;
            end else if (pc_load || take_inc) begin
                current_instruction <= NOP_INSTR;
                instruction_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, breakpoint sequence and randomized model check.
module tb_instruction_fetch;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic program_counter_increment = 1'b0;
    logic pc_load = 1'b0;
    logic [15:0] pc_load_value = '0;
    logic [7:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic [15:0] current_instruction;
    logic instruction_valid;
    logic [15:0] pc;
    logic [15:0] retired_count;
`ifdef FETCH_BREAKPOINT_EN
    logic [15:0] breakpoint_addr = '0;
    logic breakpoint_enable = 1'b0;
    logic break_hit;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] rom [256];

    instruction_fetch dut (
        .clock(clock),
        .resetn(resetn),
        .program_counter_increment(program_counter_increment),
        .pc_load(pc_load),
        .pc_load_value(pc_load_value),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
`ifdef FETCH_BREAKPOINT_EN
        .breakpoint_addr(breakpoint_addr),
        .breakpoint_enable(breakpoint_enable),
        .break_hit(break_hit),
`endif
        .current_instruction(current_instruction),
        .instruction_valid(instruction_valid),
        .pc(pc),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_rdata <= rom[imem_addr];

    typedef struct {
        logic rst_n;
        logic ld;
        logic inc;
        logic [15:0] val;
        logic [15:0] pc;
        logic v;
        logic [15:0] instr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic l, input logic i, input logic [15:0] val,
                       input logic [15:0] epc, input logic ev, input logic [15:0] ei,
                       input logic [15:0] ec);
        vt.push_back('{rst_n: r, ld: l, inc: i, val: val, pc: epc, v: ev, instr: ei, cnt: ec});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic i, input logic [15:0] val);
        resetn = r;
        pc_load = l;
        program_counter_increment = i;
        pc_load_value = val;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] epc, input logic ev,
                           input logic [15:0] ei, input logic [15:0] ec);
        chk({tag, ".pc"}, 32'(pc), 32'(epc));
        chk({tag, ".valid"}, 32'(instruction_valid), 32'(ev));
        chk({tag, ".instr"}, 32'(current_instruction), 32'(ei));
        chk({tag, ".retired"}, 32'(retired_count), 32'(ec));
        chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(epc[7:0]));
    endtask

    logic [15:0] mpc;
    logic [15:0] mcnt;
    int age;

    initial begin
        for (int k = 0; k < 256; k++) rom[k] = 16'($urandom);
        rom[8'h00] = 16'h1234;
        rom[8'h01] = 16'hABCD;
        rom[8'h02] = 16'h2222;
        rom[8'h05] = 16'h5555;
        rom[8'h10] = 16'h1010;
        rom[8'h40] = 16'h4040;
        rom[8'hFF] = 16'hBEEF;

        add(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd0);
        add(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 16'd0);
        add(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 16'd0);
        add(1, 0, 1, 16'h0000, 16'h0001, 0, 16'h0000, 16'd1);
        add(1, 0, 0, 16'h0000, 16'h0001, 0, 16'h0000, 16'd1);
        add(1, 0, 0, 16'h0000, 16'h0001, 1, 16'hABCD, 16'd1);
        add(1, 1, 1, 16'h0040, 16'h0040, 0, 16'h0000, 16'd1);
        add(1, 0, 0, 16'h0000, 16'h0040, 0, 16'h0000, 16'd1);
        add(1, 0, 0, 16'h0000, 16'h0040, 1, 16'h4040, 16'd1);
        add(1, 0, 1, 16'h0000, 16'h0041, 0, 16'h0000, 16'd2);
        add(1, 0, 1, 16'h0000, 16'h0041, 0, 16'h0000, 16'd2);
        add(1, 1, 0, 16'h0010, 16'h0010, 0, 16'h0000, 16'd2);
        add(1, 0, 0, 16'h0000, 16'h0010, 0, 16'h0000, 16'd2);
        add(1, 0, 0, 16'h0000, 16'h0010, 1, 16'h1010, 16'd2);
        add(1, 1, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 16'd2);
        add(1, 0, 0, 16'h0000, 16'hFFFF, 0, 16'h0000, 16'd2);
        add(1, 0, 0, 16'h0000, 16'hFFFF, 1, 16'hBEEF, 16'd2);
        add(1, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 16'd3);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd3);
        add(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 16'd3);
        add(1, 1, 0, 16'h0110, 16'h0110, 0, 16'h0000, 16'd3);
        add(1, 0, 0, 16'h0000, 16'h0110, 0, 16'h0000, 16'd3);
        add(1, 0, 0, 16'h0000, 16'h0110, 1, 16'h1010, 16'd3);
        add(1, 0, 1, 16'h0000, 16'h0111, 0, 16'h0000, 16'd4);
        add(1, 0, 0, 16'h0000, 16'h0111, 0, 16'h0000, 16'd4);
        add(0, 1, 1, 16'h0077, 16'h0000, 0, 16'h0000, 16'd0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd0);
        add(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 16'd0);

        @(negedge clock);
        foreach (vt[n]) begin
            step(vt[n].rst_n, vt[n].ld, vt[n].inc, vt[n].val);
            chk_all($sformatf("vec%0d", n), vt[n].pc, vt[n].v, vt[n].instr, vt[n].cnt);
        end

`ifdef FETCH_BREAKPOINT_EN
        breakpoint_addr = 16'h0002;
        breakpoint_enable = 1'b1;
        begin
            int hits = 0;
            step(0, 0, 0, 16'h0);
            chk("bp.reset_hit", 32'(break_hit), 32'd0);
            for (int s = 0; s < 9; s++) begin
                step(1, 0, s == 2 || s == 5, 16'h0);
                hits += int'(break_hit);
            end
            chk_all("bp.halt", 16'h0002, 1'b1, 16'h0300, 16'd2);
            chk("bp.hit_count", 32'(hits), 32'd1);
            step(1, 0, 0, 16'h0);
            chk("bp.hit_pulse", 32'(break_hit), 32'd0);
            chk("bp.hold_halt", 32'(current_instruction), 32'h0300);
            step(1, 1, 0, 16'h0005);
            step(1, 0, 0, 16'h0);
            step(1, 0, 0, 16'h0);
            chk_all("bp.away", 16'h0005, 1'b1, 16'h5555, 16'd2);
            chk("bp.away_hit", 32'(break_hit), 32'd0);
            step(1, 1, 0, 16'h0002);
            step(1, 0, 0, 16'h0);
            step(1, 0, 0, 16'h0);
            chk_all("bp.again", 16'h0002, 1'b1, 16'h0300, 16'd2);
            chk("bp.again_hit", 32'(break_hit), 32'd1);
            breakpoint_enable = 1'b0;
        end
`endif

        // Reference: outputs become valid two edges after the last PC write; increments only count once valid.
        step(0, 0, 0, 16'h0);
        mpc = 16'h0000;
        mcnt = 16'h0000;
        age = 0;
        chk_all("rnd.reset", mpc, 1'b0, 16'h0000, mcnt);
        for (int c = 0; c < 4000; c++) begin
            logic r, l, i;
            logic [15:0] val;
            r = $urandom_range(0, 199) != 0;
            l = $urandom_range(0, 9) == 0;
            i = $urandom_range(0, 2) == 0;
            val = $urandom_range(0, 3) == 0 ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'($urandom);
            if (!r) begin
                mpc = 16'h0000;
                mcnt = 16'h0000;
                age = 0;
            end else if (l) begin
                mpc = val;
                age = 0;
            end else if (i && age >= 2) begin
                mpc = mpc + 16'd1;
                mcnt = mcnt + 16'd1;
                age = 0;
            end else if (age < 2) begin
                age++;
            end
            step(r, l, i, val);
            chk_all($sformatf("rnd%0d", c), mpc, age >= 2, age >= 2 ? rom[mpc[7:0]] : 16'h0000, mcnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
